csr_file_m: RTL and testbench

Parametrised machine-mode CSR file for the core0 pipeline, successor to the basic CSR register bank. Reads are asynchronous from ID; writes arrive from WB with the read-modify-write operation (write/set/clear) performed inside the block. Adds hardware-maintained counters, read-only identity CSRs, trap entry/`mret` state updates, interrupt pending/enable logic and illegal-access detection.

---
 rtl/csr_file_m.sv | 193 +++++++++++++++++++
 tb/tb_csr_file_m.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
// Machine-mode CSR file: combinational reads from ID, read-modify-write commits from WB,
// free-running counters, trap/mret bookkeeping and interrupt pending logic.
module csr_file_m #(
   parameter logic [31:0] HART_ID   = 32'h0000_0000,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
   parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
   parameter int          CNT_W     = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] id_csr_raddr_i,
   input  logic        id_csr_wr_intent_i,
   output logic [31:0] csr_rdata_o,
   output logic        csr_illegal_o,
   input  logic        wb_csr_we_i,
   input  logic [11:0] wb_csr_waddr_i,
   input  logic [31:0] wb_csr_wdata_i,
   input  logic [1:0]  wb_csr_op_i,
   input  logic        wb_instret_i,
   input  logic        trap_valid_i,
   input  logic [31:0] trap_pc_i,
   input  logic [31:0] trap_cause_i,
   input  logic        mret_i,
   input  logic        irq_ext_i,
   input  logic        irq_timer_i,
   input  logic        irq_sw_i,
   output logic [31:0] trap_vector_o,
   output logic [31:0] mepc_o,
   output logic        irq_pending_o
);

   localparam logic [11:0] A_MSTATUS   = 12'h300;
   localparam logic [11:0] A_MISA      = 12'h301;
   localparam logic [11:0] A_MIE       = 12'h304;
   localparam logic [11:0] A_MTVEC     = 12'h305;
   localparam logic [11:0] A_MSCRATCH  = 12'h340;
   localparam logic [11:0] A_MEPC      = 12'h341;
   localparam logic [11:0] A_MCAUSE    = 12'h342;
   localparam logic [11:0] A_MIP       = 12'h344;
   localparam logic [11:0] A_MCYCLE    = 12'hB00;
   localparam logic [11:0] A_MCYCLEH   = 12'hB80;
   localparam logic [11:0] A_MINSTRET  = 12'hB02;
   localparam logic [11:0] A_MINSTRETH = 12'hB82;
   localparam logic [11:0] A_MHARTID   = 12'hF14;

   localparam int          HI_W      = CNT_W - 32;
   localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
   localparam logic [31:0] TVEC_MASK = 32'hFFFF_FFFD;
   localparam logic [31:0] EPC_MASK  = 32'hFFFF_FFFC;

   logic             r_mstatusMie;
   logic             r_mstatusMpie;
   logic [31:0]      r_mie;
   logic [31:0]      r_mtvec;
   logic [31:0]      r_mscratch;
   logic [31:0]      r_mepc;
   logic [31:0]      r_mcause;
   logic [CNT_W-1:0] r_mcycle;
   logic [CNT_W-1:0] r_minstret;

   logic [31:0] w_mstatusRd;
   logic [31:0] w_mip;
   logic [31:0] w_cycleHi;
   logic [31:0] w_instretHi;
   logic [31:0] w_wrOld;
   logic [31:0] w_wrNew;
   logic        w_wrCommit;
   logic [31:0] w_tvecBase;

   assign w_mstatusRd = {19'b0, 2'b11, 3'b0, r_mstatusMpie, 3'b0, r_mstatusMie, 3'b0};
   assign w_mip       = {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};
   assign w_cycleHi   = 32'(r_mcycle[CNT_W-1:32]);
   assign w_instretHi = 32'(r_minstret[CNT_W-1:32]);

   function automatic logic csrExists(input logic [11:0] addr);
      case (addr)
         A_MSTATUS, A_MISA, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MIP,
         A_MCYCLE, A_MCYCLEH, A_MINSTRET, A_MINSTRETH, A_MHARTID: csrExists = 1'b1;
         default:                                                 csrExists = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] csrRead(input logic [11:0] addr);
      case (addr)
         A_MSTATUS:   csrRead = w_mstatusRd;
         A_MISA:      csrRead = MISA_VAL;
         A_MIE:       csrRead = r_mie;
         A_MTVEC:     csrRead = r_mtvec;
         A_MSCRATCH:  csrRead = r_mscratch;
         A_MEPC:      csrRead = r_mepc;
         A_MCAUSE:    csrRead = r_mcause;
         A_MIP:       csrRead = w_mip;
         A_MCYCLE:    csrRead = r_mcycle[31:0];
         A_MCYCLEH:   csrRead = w_cycleHi;
         A_MINSTRET:  csrRead = r_minstret[31:0];
         A_MINSTRETH: csrRead = w_instretHi;
         A_MHARTID:   csrRead = HART_ID;
         default:     csrRead = 32'h0000_0000;
      endcase
   endfunction

   always_comb begin
      csr_rdata_o   = csrRead(id_csr_raddr_i);
      csr_illegal_o = !csrExists(id_csr_raddr_i) ||
                      (id_csr_wr_intent_i && (id_csr_raddr_i[11:10] == 2'b11));
   end

   always_comb begin
      w_wrOld = csrRead(wb_csr_waddr_i);
      case (wb_csr_op_i)
         2'b00:   w_wrNew = wb_csr_wdata_i;
         2'b01:   w_wrNew = w_wrOld | wb_csr_wdata_i;
         2'b10:   w_wrNew = w_wrOld & ~wb_csr_wdata_i;
         default: w_wrNew = w_wrOld;
      endcase
   end

   // A trap in the same cycle swallows every WB write.
   assign w_wrCommit = wb_csr_we_i && (wb_csr_op_i != 2'b11) && !trap_valid_i;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (w_wrCommit && (wb_csr_waddr_i == A_MCYCLE))
            r_mcycle[31:0] <= w_wrNew;
         else if (w_wrCommit && (wb_csr_waddr_i == A_MCYCLEH))
            r_mcycle[CNT_W-1:32] <= w_wrNew[HI_W-1:0];
         else
            r_mcycle <= r_mcycle + CNT_W'(1);

         if (w_wrCommit && (wb_csr_waddr_i == A_MINSTRET))
            r_minstret[31:0] <= w_wrNew;
         else if (w_wrCommit && (wb_csr_waddr_i == A_MINSTRETH))
            r_minstret[CNT_W-1:32] <= w_wrNew[HI_W-1:0];
         else if (wb_instret_i)
            r_minstret <= r_minstret + CNT_W'(1);
      end
   end

   // mret owns mstatus in its cycle; other CSR writes still land alongside it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_mstatusMie  <= 1'b0;
         r_mstatusMpie <= 1'b0;
         r_mie         <= '0;
         r_mtvec       <= MTVEC_RST & TVEC_MASK;
         r_mscratch    <= '0;
         r_mepc        <= '0;
         r_mcause      <= '0;
      end else if (trap_valid_i) begin
         r_mepc        <= trap_pc_i & EPC_MASK;
         r_mcause      <= trap_cause_i;
         r_mstatusMpie <= r_mstatusMie;
         r_mstatusMie  <= 1'b0;
      end else begin
         if (mret_i) begin
            r_mstatusMie  <= r_mstatusMpie;
            r_mstatusMpie <= 1'b1;
         end
         if (w_wrCommit) begin
            case (wb_csr_waddr_i)
               A_MSTATUS: begin
                  if (!mret_i) begin
                     r_mstatusMie  <= w_wrNew[3];
                     r_mstatusMpie <= w_wrNew[7];
                  end
               end
               A_MIE:      r_mie      <= w_wrNew & MIE_MASK;
               A_MTVEC:    r_mtvec    <= w_wrNew & TVEC_MASK;
               A_MSCRATCH: r_mscratch <= w_wrNew;
               A_MEPC:     r_mepc     <= w_wrNew & EPC_MASK;
               A_MCAUSE:   r_mcause   <= w_wrNew;
               default: ;
            endcase
         end
      end
   end

   assign w_tvecBase = {r_mtvec[31:2], 2'b00};

   always_comb begin
      if (r_mtvec[0] && r_mcause[31])
         trap_vector_o = w_tvecBase + {25'b0, r_mcause[4:0], 2'b00};
      else
         trap_vector_o = w_tvecBase;
   end

   assign mepc_o        = r_mepc;
   assign irq_pending_o = r_mstatusMie && |(r_mie & w_mip);

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: expectations are queued as stimulus is applied
// and drained against the DUT outputs once they have settled.
module tb_csr_file_m;

   localparam logic [31:0] P_HART  = 32'h0000_0003;
   localparam logic [31:0] P_TVEC  = 32'h0000_0200;
   localparam logic [31:0] P_MISA  = 32'h4000_0100;

   localparam int SEL_RDATA   = 0;
   localparam int SEL_ILLEGAL = 1;
   localparam int SEL_TVEC    = 2;
   localparam int SEL_MEPC    = 3;
   localparam int SEL_IRQ     = 4;

   logic        clk;
   logic        rst_n;
   logic [11:0] id_csr_raddr_i;
   logic        id_csr_wr_intent_i;
   logic [31:0] csr_rdata_o;
   logic        csr_illegal_o;
   logic        wb_csr_we_i;
   logic [11:0] wb_csr_waddr_i;
   logic [31:0] wb_csr_wdata_i;
   logic [1:0]  wb_csr_op_i;
   logic        wb_instret_i;
   logic        trap_valid_i;
   logic [31:0] trap_pc_i;
   logic [31:0] trap_cause_i;
   logic        mret_i;
   logic        irq_ext_i;
   logic        irq_timer_i;
   logic        irq_sw_i;
   logic [31:0] trap_vector_o;
   logic [31:0] mepc_o;
   logic        irq_pending_o;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } expT;

   expT expQ[$];
   int  checkCount = 0;
   int  failCount  = 0;

   csr_file_m #(
      .HART_ID  (P_HART),
      .MTVEC_RST(P_TVEC),
      .MISA_VAL (P_MISA),
      .CNT_W    (64)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .id_csr_raddr_i    (id_csr_raddr_i),
      .id_csr_wr_intent_i(id_csr_wr_intent_i),
      .csr_rdata_o       (csr_rdata_o),
      .csr_illegal_o     (csr_illegal_o),
      .wb_csr_we_i       (wb_csr_we_i),
      .wb_csr_waddr_i    (wb_csr_waddr_i),
      .wb_csr_wdata_i    (wb_csr_wdata_i),
      .wb_csr_op_i       (wb_csr_op_i),
      .wb_instret_i      (wb_instret_i),
      .trap_valid_i      (trap_valid_i),
      .trap_pc_i         (trap_pc_i),
      .trap_cause_i      (trap_cause_i),
      .mret_i            (mret_i),
      .irq_ext_i         (irq_ext_i),
      .irq_timer_i       (irq_timer_i),
      .irq_sw_i          (irq_sw_i),
      .trap_vector_o     (trap_vector_o),
      .mepc_o            (mepc_o),
      .irq_pending_o     (irq_pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic expectOut(input string tag, input int sel, input logic [31:0] exp);
      expT e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      expQ.push_back(e);
   endtask

   task automatic drainScoreboard();
      expT         e;
      logic [31:0] obs;
      #1;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         case (e.sel)
            SEL_RDATA:   obs = csr_rdata_o;
            SEL_ILLEGAL: obs = {31'b0, csr_illegal_o};
            SEL_TVEC:    obs = trap_vector_o;
            SEL_MEPC:    obs = mepc_o;
            default:     obs = {31'b0, irq_pending_o};
         endcase
         checkOutput(e.tag, obs, e.exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic readCheck(input string tag, input logic [11:0] addr, input logic intent,
                            input logic [31:0] expData, input logic expIllegal);
      id_csr_raddr_i     = addr;
      id_csr_wr_intent_i = intent;
      expectOut({tag, "_data"}, SEL_RDATA, expData);
      expectOut({tag, "_ill"}, SEL_ILLEGAL, {31'b0, expIllegal});
      drainScoreboard();
      id_csr_wr_intent_i = 1'b0;
   endtask

   task automatic applyStimulus(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] data);
      wb_csr_we_i    = 1'b1;
      wb_csr_waddr_i = addr;
      wb_csr_op_i    = op;
      wb_csr_wdata_i = data;
      step();
      wb_csr_we_i    = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      id_csr_raddr_i = 12'h000; id_csr_wr_intent_i = 1'b0;
      wb_csr_we_i = 1'b0; wb_csr_waddr_i = 12'h000; wb_csr_wdata_i = '0; wb_csr_op_i = 2'b00;
      wb_instret_i = 1'b0; trap_valid_i = 1'b0; trap_pc_i = '0; trap_cause_i = '0;
      mret_i = 1'b0; irq_ext_i = 1'b0; irq_timer_i = 1'b0; irq_sw_i = 1'b0;
      step();
      step();
      rst_n = 1'b1;

      readCheck("rst_mtvec", 12'h305, 1'b0, P_TVEC, 1'b0);
      expectOut("rst_tvec_out", SEL_TVEC, P_TVEC);
      expectOut("rst_irq", SEL_IRQ, 32'h0);
      expectOut("rst_mepc_out", SEL_MEPC, 32'h0);
      drainScoreboard();
      readCheck("unimpl", 12'h7C0, 1'b0, 32'h0, 1'b1);
      readCheck("hartid_wr", 12'hF14, 1'b1, P_HART, 1'b1);
      readCheck("hartid_rd", 12'hF14, 1'b0, P_HART, 1'b0);
      readCheck("misa", 12'h301, 1'b0, P_MISA, 1'b0);
      readCheck("rst_mstatus", 12'h300, 1'b0, 32'h0000_1800, 1'b0);

      applyStimulus(12'h300, 2'b00, 32'hFFFF_FFFF);
      readCheck("mstatus_warl", 12'h300, 1'b0, 32'h0000_1888, 1'b0);
      applyStimulus(12'h304, 2'b01, 32'h0000_0800);
      readCheck("mie_set", 12'h304, 1'b0, 32'h0000_0800, 1'b0);
      applyStimulus(12'h304, 2'b10, 32'h0000_0800);
      readCheck("mie_clr", 12'h304, 1'b0, 32'h0000_0000, 1'b0);
      applyStimulus(12'h301, 2'b00, 32'h0);
      readCheck("misa_ro", 12'h301, 1'b0, P_MISA, 1'b0);

      applyStimulus(12'hB80, 2'b00, 32'h0);
      applyStimulus(12'hB00, 2'b00, 32'hFFFF_FFFF);
      readCheck("mcycle_wr", 12'hB00, 1'b0, 32'hFFFF_FFFF, 1'b0);
      readCheck("mcycleh_wr", 12'hB80, 1'b0, 32'h0, 1'b0);
      step();
      readCheck("mcycle_wrap", 12'hB00, 1'b0, 32'h0, 1'b0);
      readCheck("mcycleh_carry", 12'hB80, 1'b0, 32'h1, 1'b0);

      wb_instret_i = 1'b1;
      applyStimulus(12'hB02, 2'b00, 32'h5);
      readCheck("minstret_wr", 12'hB02, 1'b0, 32'h5, 1'b0);
      repeat (3) step();
      wb_instret_i = 1'b0;
      step();
      readCheck("minstret_cnt", 12'hB02, 1'b0, 32'h8, 1'b0);

      applyStimulus(12'h305, 2'b00, 32'hFFFF_FFFF);
      readCheck("mtvec_warl", 12'h305, 1'b0, 32'hFFFF_FFFD, 1'b0);
      applyStimulus(12'h305, 2'b00, 32'h0000_0101);
      applyStimulus(12'h341, 2'b00, 32'h0000_1237);
      readCheck("mepc_warl", 12'h341, 1'b0, 32'h0000_1234, 1'b0);
      applyStimulus(12'h300, 2'b00, 32'h0000_0008);
      readCheck("mstatus_mie", 12'h300, 1'b0, 32'h0000_1808, 1'b0);

      trap_valid_i = 1'b1; trap_pc_i = 32'h8000_0102; trap_cause_i = 32'h8000_0007;
      applyStimulus(12'h341, 2'b00, 32'h0000_1234);
      trap_valid_i = 1'b0;
      readCheck("trap_mepc", 12'h341, 1'b0, 32'h8000_0100, 1'b0);
      readCheck("trap_mcause", 12'h342, 1'b0, 32'h8000_0007, 1'b0);
      readCheck("trap_mstatus", 12'h300, 1'b0, 32'h0000_1880, 1'b0);
      expectOut("trap_vector", SEL_TVEC, 32'h0000_011C);
      expectOut("trap_mepc_out", SEL_MEPC, 32'h8000_0100);
      drainScoreboard();

      mret_i = 1'b1;
      applyStimulus(12'h340, 2'b00, 32'h0000_CAFE);
      mret_i = 1'b0;
      readCheck("mret_mstatus", 12'h300, 1'b0, 32'h0000_1888, 1'b0);
      readCheck("mret_mscratch", 12'h340, 1'b0, 32'h0000_CAFE, 1'b0);
      mret_i = 1'b1;
      applyStimulus(12'h300, 2'b00, 32'h0000_0000);
      mret_i = 1'b0;
      readCheck("mret_over_wr", 12'h300, 1'b0, 32'h0000_1888, 1'b0);

      applyStimulus(12'h304, 2'b00, 32'h0000_0080);
      irq_ext_i = 1'b1;
      expectOut("irq_masked", SEL_IRQ, 32'h0);
      drainScoreboard();
      irq_ext_i   = 1'b0;
      irq_timer_i = 1'b1;
      expectOut("irq_timer", SEL_IRQ, 32'h1);
      drainScoreboard();
      readCheck("mip_read", 12'h344, 1'b0, 32'h0000_0080, 1'b0);
      applyStimulus(12'h300, 2'b10, 32'h0000_0008);
      expectOut("irq_gmask", SEL_IRQ, 32'h0);
      drainScoreboard();
      irq_timer_i = 1'b0;

      rst_n = 1'b0;
      trap_valid_i = 1'b1; trap_pc_i = 32'h0000_4444;
      applyStimulus(12'h340, 2'b00, 32'h0000_0055);
      trap_valid_i = 1'b0;
      rst_n = 1'b1;
      readCheck("mid_rst_mscratch", 12'h340, 1'b0, 32'h0, 1'b0);
      readCheck("mid_rst_mepc", 12'h341, 1'b0, 32'h0, 1'b0);
      readCheck("mid_rst_mtvec", 12'h305, 1'b0, P_TVEC, 1'b0);
      readCheck("mid_rst_mcycle", 12'hB00, 1'b0, 32'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
